// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with one-shot or auto-reload operation.
//                A load moves the timer into RUN; each enabled RUN cycle
//                decrements the count until it reaches LOWER, at which point
//                the timer expires (registered done pulse + sticky expired).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          : clock, all state changes on rising edge
//    rst_i          : synchronous reset, active low
//    ena_i          : count enable (one decrement per enabled RUN cycle)
//    load_valid_i   : load request
//    load_value_i   : requested start count (clamped to UPPER)
//    load_ready_o   : high when a load can be accepted (IDLE / EXPIRED)
//    abort_i        : cancel an active countdown
//    expired_clr_i  : clear the sticky expired flag
//    value_o        : current count register
//    busy_o         : high while in RUN
//    done_o         : single-cycle registered expiry pulse
//    expired_o      : sticky registered expiry flag
// ============================================================================
module countdown_timer #(
  parameter  int LOWER      = 0,
  parameter  int UPPER      = 255,
  parameter  int PERIODIC   = 0,
  parameter  int INIT_VALUE = UPPER,
  localparam int WIDTH      = (UPPER < 2) ? 1 : $clog2(UPPER + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             load_ready_o,
  input  logic             abort_i,
  input  logic             expired_clr_i,
  output logic [WIDTH-1:0] value_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             expired_o
);

  localparam logic [WIDTH-1:0] C_LOWER = WIDTH'(LOWER);
  localparam logic [WIDTH-1:0] C_UPPER = WIDTH'(UPPER);
  localparam logic [WIDTH-1:0] C_INIT  = WIDTH'(INIT_VALUE);

  generate
    if (UPPER <= LOWER) begin : g_bad_params
      $error("countdown_timer: UPPER must be greater than LOWER");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic             done_q,    done_d;
  logic             expired_q, expired_d;

  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (load_value_i > C_UPPER) ? C_UPPER : load_value_i;

  // Ready is forced low during reset so no handshake completes while the
  // block is being initialised.
  assign load_ready_o = rst_i && (state_q != S_RUN);
  assign value_o      = count_q;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = done_q;
  assign expired_o    = expired_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= C_INIT;
      reload_q  <= C_INIT;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    // A set below overrides this clear when both happen together.
    expired_d = expired_q & ~expired_clr_i;

    case (state_q)
      S_IDLE, S_EXPIRED: begin
        if (load_valid_i) begin
          count_d  = load_clamped;
          reload_d = load_clamped;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (ena_i) begin
          // "<=" so that a start value loaded below LOWER expires at once
          // instead of wrapping.
          if (count_q <= C_LOWER) begin
            done_d    = 1'b1;
            expired_d = 1'b1;
            if (PERIODIC != 0) begin
              count_d = reload_q;
            end else begin
              state_d = S_EXPIRED;
            end
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. A one-shot instance
//                (UPPER=200) is driven from a vector table; an auto-reload
//                instance (UPPER=15, INIT_VALUE=10) is driven by a hand-written
//                sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // one-shot instance
  logic       a_rst = 1'b0, a_ena = 1'b0, a_lv = 1'b0, a_abort = 1'b0, a_clr = 1'b0;
  logic [7:0] a_lval = 8'd0;
  logic [7:0] a_value;
  logic       a_ready, a_busy, a_done, a_exp;

  countdown_timer #(.LOWER(0), .UPPER(200), .PERIODIC(0)) u_oneshot (
    .clk_i         (clk),
    .rst_i         (a_rst),
    .ena_i         (a_ena),
    .load_valid_i  (a_lv),
    .load_value_i  (a_lval),
    .load_ready_o  (a_ready),
    .abort_i       (a_abort),
    .expired_clr_i (a_clr),
    .value_o       (a_value),
    .busy_o        (a_busy),
    .done_o        (a_done),
    .expired_o     (a_exp)
  );

  // auto-reload instance
  logic       b_rst = 1'b0, b_ena = 1'b0, b_lv = 1'b0, b_abort = 1'b0, b_clr = 1'b0;
  logic [3:0] b_lval = 4'd0;
  logic [3:0] b_value;
  logic       b_ready, b_busy, b_done, b_exp;

  countdown_timer #(.LOWER(0), .UPPER(15), .PERIODIC(1), .INIT_VALUE(10)) u_periodic (
    .clk_i         (clk),
    .rst_i         (b_rst),
    .ena_i         (b_ena),
    .load_valid_i  (b_lv),
    .load_value_i  (b_lval),
    .load_ready_o  (b_ready),
    .abort_i       (b_abort),
    .expired_clr_i (b_clr),
    .value_o       (b_value),
    .busy_o        (b_busy),
    .done_o        (b_done),
    .expired_o     (b_exp)
  );

  typedef struct {
    logic       rst, ena, lv;
    logic [7:0] lval;
    logic       abort, clr;
    logic [7:0] e_value;
    logic       e_busy, e_done, e_exp, e_ready;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, ena, lv, input logic [7:0] lval,
                     input logic abort, clr, input logic [7:0] ev,
                     input logic eb, ed, ee, er);
    vec_t v;
    v.rst = rst; v.ena = ena; v.lv = lv; v.lval = lval; v.abort = abort; v.clr = clr;
    v.e_value = ev; v.e_busy = eb; v.e_done = ed; v.e_exp = ee; v.e_ready = er;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    //   rst ena lv lval ab clr | value busy done exp ready
    add(0, 0, 0,   0, 0, 0,  200, 0, 0, 0, 0);  // reset state
    add(1, 0, 0,   0, 0, 0,  200, 0, 0, 0, 1);  // idle after release
    add(1, 0, 1,   3, 0, 0,    3, 1, 0, 0, 0);  // load 3
    add(1, 1, 0,   0, 0, 0,    2, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    1, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    0, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    0, 0, 1, 1, 1);  // expiry
    add(1, 1, 0,   0, 0, 0,    0, 0, 0, 1, 1);  // done is one cycle only
    add(1, 0, 0,   0, 0, 1,    0, 0, 0, 0, 1);  // clear sticky
    add(1, 0, 1, 250, 0, 0,  200, 1, 0, 0, 0);  // clamp to UPPER
    add(1, 1, 0,   0, 0, 0,  199, 1, 0, 0, 0);
    add(1, 0, 0,   0, 0, 0,  199, 1, 0, 0, 0);  // gated
    add(1, 1, 0,   0, 0, 0,  198, 1, 0, 0, 0);
    add(1, 1, 0,   0, 1, 0,  198, 0, 0, 0, 1);  // abort beats decrement
    add(1, 1, 0,   0, 1, 0,  198, 0, 0, 0, 1);  // abort in IDLE ignored
    add(1, 0, 1,   5, 0, 0,    5, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    4, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    3, 1, 0, 0, 0);
    add(1, 0, 0,   0, 1, 0,    3, 0, 0, 0, 1);  // abort holds value 3
    add(1, 0, 1,   0, 0, 0,    0, 1, 0, 0, 0);  // load LOWER
    add(1, 1, 0,   0, 1, 0,    0, 0, 0, 0, 1);  // abort beats expiry
    add(1, 0, 1,   1, 0, 0,    1, 1, 0, 0, 0);
    add(1, 1, 1,   9, 0, 0,    0, 1, 0, 0, 0);  // load in RUN ignored
    add(1, 1, 0,   0, 0, 1,    0, 0, 1, 1, 1);  // set beats clear
    add(1, 0, 0,   0, 0, 1,    0, 0, 0, 0, 1);  // clear next cycle
    add(1, 0, 1,   0, 0, 0,    0, 1, 0, 0, 0);
    add(1, 1, 0,   0, 0, 0,    0, 0, 1, 1, 1);  // immediate expiry
    add(1, 0, 1,   2, 0, 0,    2, 1, 0, 1, 0);  // load keeps expired
    add(1, 0, 0,   0, 0, 0,    2, 1, 0, 1, 0);  // ena=0 holds
    add(1, 0, 0,   0, 1, 0,    2, 0, 0, 1, 1);  // abort keeps expired
    add(1, 0, 1,   8, 0, 0,    8, 1, 0, 1, 0);
    add(1, 1, 0,   0, 0, 0,    7, 1, 0, 1, 0);
    add(0, 1, 0,   0, 0, 0,  200, 0, 0, 0, 0);  // reset mid-RUN at 7
    add(1, 0, 0,   0, 0, 0,  200, 0, 0, 0, 1);  // ready back after release
    add(1, 0, 1,   0, 0, 0,    0, 1, 0, 0, 0);
    add(0, 1, 0,   0, 0, 0,  200, 0, 0, 0, 0);  // reset beats expiry
    add(1, 0, 0,   0, 0, 0,  200, 0, 0, 0, 1);  // no done afterwards

    for (int i = 0; i < tbl.size(); i++) begin
      a_rst = tbl[i].rst; a_ena = tbl[i].ena; a_lv = tbl[i].lv; a_lval = tbl[i].lval;
      a_abort = tbl[i].abort; a_clr = tbl[i].clr;
      @(posedge clk); #1;
      check("value",   i, int'(a_value), int'(tbl[i].e_value));
      check("busy",    i, int'(a_busy),  int'(tbl[i].e_busy));
      check("done",    i, int'(a_done),  int'(tbl[i].e_done));
      check("expired", i, int'(a_exp),   int'(tbl[i].e_exp));
      check("ready",   i, int'(a_ready), int'(tbl[i].e_ready));
    end

    // ---------------- auto-reload sequence ----------------
    b_rst = 1'b0;
    @(posedge clk); #1;
    check("p_reset_value", 0, int'(b_value), 10);
    check("p_reset_busy",  0, int'(b_busy),  0);
    b_rst = 1'b1; b_lv = 1'b1; b_lval = 4'd2;
    @(posedge clk); #1;
    check("p_load_value", 0, int'(b_value), 2);
    check("p_load_busy",  0, int'(b_busy),  1);
    b_lv = 1'b0; b_ena = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("p_value", i, int'(b_value), 2 - ((i + 1) % 3));
      check("p_done",  i, int'(b_done),  ((i + 1) % 3 == 0) ? 1 : 0);
      check("p_busy",  i, int'(b_busy),  1);
    end
    check("p_expired", 0, int'(b_exp), 1);
    // count down to 0, then abort on the would-be reload cycle
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("p_at_zero", 0, int'(b_value), 0);
    b_abort = 1'b1;
    @(posedge clk); #1;
    check("p_abort_value", 0, int'(b_value), 0);
    check("p_abort_busy",  0, int'(b_busy),  0);
    check("p_abort_done",  0, int'(b_done),  0);
    check("p_abort_ready", 0, int'(b_ready), 1);
    b_abort = 1'b0; b_ena = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
